// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - interrupt request arbiter with req/ack/eoi handshake to the CPU
//
// Purpose:
//   Latches rising edges of the interrupt sources into pending bits. It picks
//   one unmasked pending source and presents it to the CPU. It then walks the
//   request / acknowledge / end-of-interrupt handshake.
//
// Ports:
//   sysclk    in   system clock, posedge
//   reset     in   asynchronous active-high reset
//   irq_src   in   [NUM_SRC] interrupt sources, rising edge = one request
//   irq_mask  in   [NUM_SRC] 1 = source not selectable (pending still latches)
//   cpu_ack   in   CPU accepts the presented interrupt (REQ only)
//   cpu_eoi   in   CPU handler finished (SERVICE only)
//   lost_clr  in   clears all lost bits
//   cpu_irq   out  interrupt request to the CPU
//   irq_id    out  [ID_W] presented / in-service source index
//   pending   out  [NUM_SRC] latched, not yet acknowledged requests
//   lost      out  [NUM_SRC] sticky, edge arrived while already pending
//   timeout   out  one-cycle pulse when a request was abandoned
//
// Optional feature macro: IRQ_ROUND_ROBIN_EN
//   The macro is undefined by default. Selection is then fixed priority, and
//   the lowest index wins.
//   When the macro is defined, selection is round-robin. The search starts
//   after the last acknowledged source.
module irq_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  input  logic               lost_clr,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] lost,
  output logic               timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] lost_q, lost_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               cpu_irq_q, cpu_irq_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic               ack_take;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

  assign src_rise = irq_src & ~prev_q;
  assign eligible = pending_q & ~irq_mask;
  assign ack_take = (state_q == S_REQ) && cpu_ack;

  // One-hot clear of the served source on acknowledge.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_take && (irq_id_q == ID_W'(i))) clr[i] = 1'b1;
    end
  end

  // A new edge beats a simultaneous clear. A lost request is counted only
  // when the bit stays pending, because the clear did not take it away.
  // A new lost event beats lost_clr.
  assign pending_d = (pending_q & ~clr) | src_rise;
  assign lost_d    = (lost_clr ? '0 : lost_q) | (src_rise & pending_q & ~clr);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_q, last_d;
  int              rr_dist;
  int              rr_best;

  // Each eligible source gets a distance, counted from the slot after
  // last_q. The smallest distance wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    rr_dist   = 0;
    rr_best   = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      rr_dist = i - int'(last_q) - 1;
      if (rr_dist < 0) rr_dist = rr_dist + NUM_SRC;
      if (eligible[i] && (rr_dist < rr_best)) begin
        rr_best   = rr_dist;
        win_id    = ID_W'(i);
        win_valid = 1'b1;
      end
    end
  end

  // Only an accepted interrupt moves the pointer; timeouts leave it alone.
  assign last_d = ack_take ? irq_id_q : last_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) last_q <= ID_W'(NUM_SRC - 1);
    else       last_q <= last_d;
  end
`else
  // Descending scan so the lowest eligible index is assigned last.
  always_comb begin
    win_valid = |eligible;
    win_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    cpu_irq_d = cpu_irq_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cpu_irq_d = 1'b0;
        if (win_valid) begin
          irq_id_d  = win_id;
          cpu_irq_d = 1'b1;
          cnt_d     = CNT_W'(ACK_TIMEOUT);
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (cpu_ack) begin
          cpu_irq_d = 1'b0;
          state_d   = S_SERVICE;
        end else if (cnt_q == CNT_W'(1)) begin
          // The counter would reach zero on this edge, so the request is
          // abandoned. The pending bit stays set.
          cpu_irq_d = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SERVICE: begin
        cpu_irq_d = 1'b0;
        if (cpu_eoi) state_d = S_IDLE;
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      irq_id_q  <= '0;
      cpu_irq_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= irq_src;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      irq_id_q  <= irq_id_d;
      cpu_irq_q <= cpu_irq_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_irq = cpu_irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign lost    = lost_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb/tb_irq_arbiter.sv - directed vector bench for irq_arbiter
module tb_irq_arbiter;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic [3:0] irq_mask;
  logic       cpu_ack;
  logic       cpu_eoi;
  logic       lost_clr;
  logic       cpu_irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] lost;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  irq_arbiter #(
    .NUM_SRC    (4),
    .ID_W       (2),
    .ACK_TIMEOUT(4)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .irq_src (irq_src),
    .irq_mask(irq_mask),
    .cpu_ack (cpu_ack),
    .cpu_eoi (cpu_eoi),
    .lost_clr(lost_clr),
    .cpu_irq (cpu_irq),
    .irq_id  (irq_id),
    .pending (pending),
    .lost    (lost),
    .timeout (timeout)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [3:0] src;
    logic [3:0] mask;
    logic       ack;
    logic       eoi;
    logic       lclr;
    logic       e_irq;
    logic [1:0] e_id;
    logic [3:0] e_pend;
    logic [3:0] e_lost;
    logic       e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic [3:0] src, input logic ack, input logic eoi,
                      input logic lclr, input logic e_irq, input logic [1:0] e_id,
                      input logic [3:0] e_pend, input logic [3:0] e_lost);
    vec_t v;
    v.src = src; v.mask = 4'b0000; v.ack = ack; v.eoi = eoi; v.lclr = lclr;
    v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_lost = e_lost; v.e_to = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_irq, input logic [1:0] e_id,
                         input logic [3:0] e_pend, input logic [3:0] e_lost, input logic e_to);
    check({tag, ".cpu_irq"}, 32'(cpu_irq), 32'(e_irq));
    check({tag, ".irq_id"},  32'(irq_id),  32'(e_id));
    check({tag, ".pending"}, 32'(pending), 32'(e_pend));
    check({tag, ".lost"},    32'(lost),    32'(e_lost));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  task automatic setin(input logic [3:0] src, input logic [3:0] mask, input logic ack,
                       input logic eoi, input logic lclr);
    irq_src = src; irq_mask = mask; cpu_ack = ack; cpu_eoi = eoi; lost_clr = lclr;
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    setin(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sysclk);
    #1;
    chk_out("reset", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;

    //   src      ack  eoi  lclr  irq  id  pend     lost
    addv(4'b0100, 0,   0,   0,    0,   0,  4'b0100, 4'b0000); // 0  single request latched
    addv(4'b0000, 0,   0,   0,    1,   2,  4'b0100, 4'b0000); // 1  presented next edge
    addv(4'b0000, 1,   0,   0,    0,   2,  4'b0000, 4'b0000); // 2  ack clears
    addv(4'b0000, 0,   0,   0,    0,   2,  4'b0000, 4'b0000); // 3  service
    addv(4'b0000, 0,   1,   0,    0,   2,  4'b0000, 4'b0000); // 4  eoi
    addv(4'b1010, 0,   0,   0,    0,   2,  4'b1010, 4'b0000); // 5  sources 3 and 1
    addv(4'b0000, 0,   0,   0,    1,   1,  4'b1010, 4'b0000); // 6  lower index first
    addv(4'b0000, 1,   0,   0,    0,   1,  4'b1000, 4'b0000); // 7
    addv(4'b0000, 0,   1,   0,    0,   1,  4'b1000, 4'b0000); // 8  eoi -> one idle cycle
    addv(4'b0000, 0,   0,   0,    1,   3,  4'b1000, 4'b0000); // 9  then source 3
    addv(4'b0000, 1,   0,   0,    0,   3,  4'b0000, 4'b0000); // 10
    addv(4'b0000, 0,   1,   0,    0,   3,  4'b0000, 4'b0000); // 11
    addv(4'b0001, 0,   0,   0,    0,   3,  4'b0001, 4'b0000); // 12 source 0
    addv(4'b0000, 0,   0,   0,    1,   0,  4'b0001, 4'b0000); // 13
    addv(4'b0001, 0,   0,   0,    1,   0,  4'b0001, 4'b0001); // 14 second edge -> lost
    addv(4'b0000, 0,   0,   1,    1,   0,  4'b0001, 4'b0000); // 15 lost_clr
    addv(4'b0001, 1,   0,   0,    0,   0,  4'b0001, 4'b0000); // 16 edge with ack: stays, no lost
    addv(4'b0000, 0,   1,   0,    0,   0,  4'b0001, 4'b0000); // 17
    addv(4'b0000, 0,   0,   0,    1,   0,  4'b0001, 4'b0000); // 18 re-presented
    addv(4'b0000, 1,   0,   0,    0,   0,  4'b0000, 4'b0000); // 19
    addv(4'b0000, 0,   1,   0,    0,   0,  4'b0000, 4'b0000); // 20
    addv(4'b0000, 1,   1,   0,    0,   0,  4'b0000, 4'b0000); // 21 ack/eoi ignored in idle
    addv(4'b0001, 0,   0,   0,    0,   0,  4'b0001, 4'b0000); // 22
    addv(4'b0000, 0,   0,   0,    1,   0,  4'b0001, 4'b0000); // 23
    addv(4'b0001, 0,   0,   1,    1,   0,  4'b0001, 4'b0001); // 24 lost set beats lost_clr
    addv(4'b0000, 1,   0,   0,    0,   0,  4'b0000, 4'b0001); // 25
    addv(4'b0000, 0,   1,   1,    0,   0,  4'b0000, 4'b0000); // 26

    for (int i = 0; i < vecs.size(); i++) begin
      setin(vecs[i].src, vecs[i].mask, vecs[i].ack, vecs[i].eoi, vecs[i].lclr);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_id, vecs[i].e_pend,
              vecs[i].e_lost, vecs[i].e_to);
    end

    // Timeout: four cycles high, one pulse, re-presented; then ack on the expiry edge.
    setin(4'b0010, 4'b0000, 0, 0, 0); step();
    chk_out("to.latch", 1'b0, 2'd0, 4'b0010, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 0, 0, 0); step();
    chk_out("to.req", 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    repeat (3) begin
      step();
      chk_out("to.hold", 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    end
    step();
    chk_out("to.expire", 1'b0, 2'd1, 4'b0010, 4'b0000, 1'b1);
    step();
    chk_out("to.repres", 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    repeat (3) begin
      step();
      chk_out("to.hold2", 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0);
    end
    setin(4'b0000, 4'b0000, 1, 0, 0); step();
    chk_out("to.ackwins", 1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 0, 1, 0); step();
    setin(4'b0000, 4'b0000, 0, 0, 0);

    // Mask: pending source 2 held back for 20 cycles, served once unmasked.
    setin(4'b0100, 4'b0100, 0, 0, 0); step();
    chk_out("mask.latch", 1'b0, 2'd1, 4'b0100, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0100, 0, 0, 0);
    repeat (20) begin
      step();
      chk_out("mask.hold", 1'b0, 2'd1, 4'b0100, 4'b0000, 1'b0);
    end
    setin(4'b0000, 4'b0000, 0, 0, 0); step();
    chk_out("mask.release", 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 1, 0, 0); step();
    setin(4'b0000, 4'b0000, 0, 1, 0); step();
    setin(4'b0000, 4'b0000, 0, 0, 0);

    // Async reset while in REQ with a lost bit set.
    setin(4'b0001, 4'b0000, 0, 0, 0); step();
    setin(4'b0000, 4'b0000, 0, 0, 0); step();
    setin(4'b0001, 4'b0000, 0, 0, 0); step();
    chk_out("rst1.pre", 1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
    setin(4'b0000, 4'b0000, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_out("rst1.async", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step();
    reset = 1'b0;
    setin(4'b0100, 4'b0000, 0, 0, 0); step();
    chk_out("rst1.new", 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 0, 0, 0); step();
    chk_out("rst1.serve", 1'b1, 2'd2, 4'b0100, 4'b0000, 1'b0);

    // Async reset while in SERVICE with another request pending.
    setin(4'b0000, 4'b0000, 1, 0, 0); step();
    setin(4'b1000, 4'b0000, 0, 0, 0); step();
    chk_out("rst2.pre", 1'b0, 2'd2, 4'b1000, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 0, 0, 0);
    #2 reset = 1'b1;
    #1 chk_out("rst2.async", 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0);
    step();
    reset = 1'b0;
    setin(4'b0001, 4'b0000, 0, 0, 0); step();
    chk_out("rst2.new", 1'b0, 2'd0, 4'b0001, 4'b0000, 1'b0);
    setin(4'b0000, 4'b0000, 0, 0, 0); step();
    chk_out("rst2.serve", 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
